ucsbece154_icache_cwf: RTL and testbench

Parametrised N-way set-associative, read-only instruction cache between the fetch stage and the SDRAM controller.
- Adds critical-word-first refill with early restart.
- Adds per-set round-robin replacement.
- Adds a whole-cache flush.
- Adds saturating hit/miss performance counters.
Hits return in one cycle; misses stall the core via Busy until the line is filled.

---
 rtl/ucsbece154_icache_cwf.sv | 172 +++++++++++++++++
 tb/tb_ucsbece154_icache_cwf.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154_icache_cwf.sv
// N-way set-associative read-only instruction cache.
// Critical-word-first refill, round-robin replacement, flush, perf counters.
module ucsbece154_icache_cwf #(
  parameter int NUM_SETS    = 8,
  parameter int NUM_WAYS    = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int WORD_SIZE   = 32,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ReadEnable,
  input  logic [31:0]          ReadAddress,
  input  logic                 Flush,
  output logic [WORD_SIZE-1:0] Instruction,
  output logic                 Ready,
  output logic                 Busy,
  output logic [31:0]          MemReadAddress,
  output logic                 MemReadRequest,
  input  logic [31:0]          MemDataIn,
  input  logic                 MemDataReady,
  output logic [CNT_WIDTH-1:0] HitCount,
  output logic [CNT_WIDTH-1:0] MissCount
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int TAG_W = 30 - OFF_W - SET_W;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state, state_n;

  logic [OFF_W-1:0] a_off;
  logic [SET_W-1:0] a_set;
  logic [TAG_W-1:0] a_tag;
  logic [1:0]       unused_addr;

  assign a_off       = ReadAddress[OFF_W+1:2];
  assign a_set       = ReadAddress[OFF_W+SET_W+1:OFF_W+2];
  assign a_tag       = ReadAddress[31:OFF_W+SET_W+2];
  assign unused_addr = ReadAddress[1:0];

  logic [WORD_SIZE-1:0] data_q [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
  logic [TAG_W-1:0]     tag_q  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
  logic [WAY_W-1:0]     rr_q    [NUM_SETS];

  logic [SET_W-1:0] rset_q;
  logic [TAG_W-1:0] rtag_q;
  logic [WAY_W-1:0] rway_q;
  logic [OFF_W-1:0] crit_q;
  logic [OFF_W-1:0] beat_q;
  logic [OFF_W-1:0] woff;
  logic             rwas_valid_q;
  logic             flush_pend_q;

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             has_inv;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] victim;

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[a_set][w] && tag_q[a_set][w] == a_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[a_set][w]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    victim = has_inv ? inv_way : rr_q[a_set];
  end

  logic lookup, do_hit, do_miss, beat, last;

  assign lookup  = (state == IDLE) && ReadEnable && !Flush;
  assign do_hit  = lookup && hit;
  assign do_miss = lookup && !hit;
  assign beat    = (state == REFILL) && MemDataReady;
  assign last    = beat && (beat_q == OFF_W'(BLOCK_WORDS - 1));
  assign woff    = crit_q + beat_q;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n        = state;
    Busy           = (state == REFILL);
    MemReadRequest = (state == REFILL);
    unique case (state)
      IDLE:    if (do_miss) state_n = REFILL;
      REFILL:  if (last)    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset && beat) data_q[rset_q][rway_q][woff] <= MemDataIn;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Instruction    <= '0;
      Ready          <= 1'b0;
      MemReadAddress <= '0;
      HitCount       <= '0;
      MissCount      <= '0;
      flush_pend_q   <= 1'b0;
      beat_q         <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      Ready <= 1'b0;
      if (state == IDLE && Flush) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          valid_q[s] <= '0;
          rr_q[s]    <= '0;
        end
      end
      if (do_hit) begin
        Instruction <= data_q[a_set][hit_way][a_off];
        Ready       <= 1'b1;
        if (HitCount != '1) HitCount <= HitCount + CNT_WIDTH'(1);
      end
      if (do_miss) begin
        MemReadAddress <= {ReadAddress[31:2], 2'b00};
        rset_q         <= a_set;
        rtag_q         <= a_tag;
        rway_q         <= victim;
        rwas_valid_q   <= !has_inv;
        crit_q         <= a_off;
        beat_q         <= '0;
        flush_pend_q   <= 1'b0;
        if (MissCount != '1) MissCount <= MissCount + CNT_WIDTH'(1);
      end
      if (state == REFILL && Flush) flush_pend_q <= 1'b1;
      if (beat) begin
        beat_q <= beat_q + OFF_W'(1);
        if (beat_q == '0) begin
          Instruction <= MemDataIn;
          Ready       <= 1'b1;
        end
        if (last) begin
          tag_q[rset_q][rway_q] <= rtag_q;
          // A flush seen anywhere during the refill also drops the new line.
          if (flush_pend_q || Flush) begin
            for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
          end else begin
            valid_q[rset_q][rway_q] <= 1'b1;
          end
          if (rwas_valid_q) rr_q[rset_q] <= rr_q[rset_q] + WAY_W'(1);
          flush_pend_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154_icache_cwf.sv
// Bench for ucsbece154_icache_cwf: directed plan plus random traffic
// against a behavioural cache model and an in-bench SDRAM responder.
module tb_ucsbece154_icache_cwf;

  localparam int NS = 8;
  localparam int NW = 4;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, ren = 1'b0, flush = 1'b0, mdr = 1'b0;
  logic [31:0] raddr = '0, mdin = '0;
  logic [31:0] instr, maddr, hits, misses;
  logic        ready, busy, mreq;
  logic [31:0] unused_instr3, unused_maddr3;
  logic        unused_ready3, unused_busy3, unused_mreq3;
  logic [2:0]  hits3, miss3;

  ucsbece154_icache_cwf dut (
    .Clk(clk), .Reset(reset), .ReadEnable(ren), .ReadAddress(raddr),
    .Flush(flush), .Instruction(instr), .Ready(ready), .Busy(busy),
    .MemReadAddress(maddr), .MemReadRequest(mreq), .MemDataIn(mdin),
    .MemDataReady(mdr), .HitCount(hits), .MissCount(misses)
  );

  ucsbece154_icache_cwf #(.CNT_WIDTH(3)) u_sat (
    .Clk(clk), .Reset(reset), .ReadEnable(ren), .ReadAddress(raddr),
    .Flush(flush), .Instruction(unused_instr3), .Ready(unused_ready3),
    .Busy(unused_busy3), .MemReadAddress(unused_maddr3),
    .MemReadRequest(unused_mreq3), .MemDataIn(mdin), .MemDataReady(mdr),
    .HitCount(hits3), .MissCount(miss3)
  );

  int checks = 0, failures = 0;

  // Backing store contents: a fixed bijection of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h0000_00E0;
  endfunction

  bit          m_valid [NS][NW];
  int unsigned m_tag   [NS][NW];
  int          m_rr    [NS];
  logic [31:0] e_instr = '0, e_maddr = '0, e_hits = '0, e_miss = '0;
  logic        e_ready = 1'b0, e_busy = 1'b0;
  int          e_h3 = 0, e_m3 = 0;
  int          r_set, r_way, r_crit, r_beats;
  int unsigned r_tag;
  bit          r_was, r_fp;

  task automatic clear_valid(input bit with_rr);
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
      if (with_rr) m_rr[s] = 0;
    end
  endtask

  task automatic model_edge();
    int s, o, w, v;
    int unsigned t;
    e_ready = 1'b0;
    if (reset) begin
      clear_valid(1'b1);
      e_instr = '0; e_maddr = '0; e_busy = 1'b0;
      e_hits = '0; e_miss = '0; e_h3 = 0; e_m3 = 0; r_fp = 1'b0;
    end else if (!e_busy) begin
      if (flush) begin
        clear_valid(1'b1);
      end else if (ren) begin
        s = int'((raddr >> 4) % NS);
        o = int'((raddr >> 2) % BW);
        t = raddr >> 7;
        w = -1;
        for (int i = 0; i < NW; i++)
          if (m_valid[s][i] && m_tag[s][i] == t) w = i;
        if (w >= 0) begin
          e_instr = memf(raddr);
          e_ready = 1'b1;
          if (e_hits != 32'hFFFF_FFFF) e_hits = e_hits + 1;
          if (e_h3 < 7) e_h3++;
        end else begin
          v = -1;
          for (int i = NW - 1; i >= 0; i--) if (!m_valid[s][i]) v = i;
          r_was = (v < 0);
          if (v < 0) v = m_rr[s];
          r_set = s; r_tag = t; r_way = v; r_crit = o;
          r_beats = 0; r_fp = 1'b0;
          e_busy = 1'b1;
          e_maddr = {raddr[31:2], 2'b00};
          if (e_miss != 32'hFFFF_FFFF) e_miss = e_miss + 1;
          if (e_m3 < 7) e_m3++;
        end
      end
    end else begin
      if (flush) r_fp = 1'b1;
      if (mdr) begin
        if (r_beats == 0) begin
          e_instr = memf(e_maddr);
          e_ready = 1'b1;
        end
        r_beats++;
        if (r_beats == BW) begin
          m_tag[r_set][r_way] = r_tag;
          if (r_fp) clear_valid(1'b0);
          else m_valid[r_set][r_way] = 1'b1;
          if (r_was) m_rr[r_set] = (m_rr[r_set] + 1) % NW;
          r_fp = 1'b0;
          e_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  int   mem_n = 0, gap_mode = 0;
  bit   mreq_prev = 1'b0, gap_done = 1'b0, saw_ready = 1'b0;
  logic [31:0] got_instr = '0;

  // One clock: model at the edge, compare and drive memory at the falling edge.
  task automatic step();
    logic [31:0] a;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("ready", 32'(ready), 32'(e_ready));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("mreq", 32'(mreq), 32'(e_busy));
    if (e_ready) chk("instr", instr, e_instr);
    if (e_busy) chk("maddr", maddr, e_maddr);
    chk("hits", hits, e_hits);
    chk("misses", misses, e_miss);
    chk("hits_sat", 32'(hits3), 32'(e_h3));
    chk("miss_sat", 32'(miss3), 32'(e_m3));
    if (ready) begin
      saw_ready = 1'b1;
      got_instr = instr;
    end
    if (mdr && mreq_prev) mem_n++;
    if (!mreq) mem_n = 0;
    mreq_prev = mreq;
    mdr  = 1'b0;
    mdin = '0;
    if (mreq && mem_n < BW) begin
      if (gap_mode == 1 && mem_n == 2 && !gap_done) begin
        gap_done = 1'b1;
      end else if (gap_mode == 2 && $urandom_range(0, 3) == 0) begin
        mdr = 1'b0;
      end else begin
        a = (maddr & ~32'(BW * 4 - 1)) +
            32'(((int'(maddr >> 2) + mem_n) % BW) * 4);
        mdr  = 1'b1;
        mdin = memf(a);
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 40) begin
      step();
      k++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL %s: busy=%0b after %0d cycles, expected 0", nm, busy, k);
    end
  endtask

  task automatic wait_ready(input string nm);
    int k = 0;
    while (!saw_ready && k < 40) begin
      step();
      k++;
    end
    checks++;
    if (!saw_ready) begin
      failures++;
      $display("FAIL %s: no Ready after %0d cycles, expected one", nm, k);
    end
  endtask

  task automatic read(input logic [31:0] a);
    ren = 1'b1;
    raddr = a;
    step();
    ren = 1'b0;
  endtask

  logic [31:0] t3a [3] = '{32'h40, 32'h44, 32'h4C};
  logic [31:0] t3d [3] = '{32'hA0, 32'hA4, 32'hAC};
  logic [31:0] t4a [5] = '{32'h048, 32'h248, 32'h448, 32'h648, 32'h848};

  initial begin
    step();
    step();
    reset = 1'b0;
    chk("rst_instr", instr, 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_maddr", maddr, 32'h0);
    chk("rst_mreq", 32'(mreq), 32'h0);
    chk("rst_hits", hits, 32'h0);
    chk("rst_miss", misses, 32'h0);

    gap_mode = 1;
    gap_done = 1'b0;
    saw_ready = 1'b0;
    read(32'h48);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_mreq", 32'(mreq), 32'h1);
    chk("t1_maddr", maddr, 32'h48);
    chk("t1_miss", misses, 32'h1);
    wait_ready("t2_ready");
    chk("t2_crit", got_instr, 32'hA8);
    chk("t2_busy_early", 32'(busy), 32'h1);
    wait_idle("t2_idle");
    gap_mode = 0;

    ren = 1'b1;
    for (int i = 0; i < 3; i++) begin
      raddr = t3a[i];
      step();
      chk("t3_ready", 32'(ready), 32'h1);
      chk("t3_instr", instr, t3d[i]);
      chk("t3_mreq", 32'(mreq), 32'h0);
    end
    ren = 1'b0;
    chk("t3_hits", hits, 32'h3);

    flush = 1'b1;
    read(32'h40);
    flush = 1'b0;
    chk("t4_flush_drop", 32'(ready), 32'h0);
    chk("t4_flush_hits", hits, 32'h3);
    for (int i = 0; i < 5; i++) begin
      read(t4a[i]);
      chk("t4_fill_miss", 32'(busy), 32'h1);
      wait_idle("t4_fill_idle");
    end
    read(32'h248);
    chk("t4_hit_248", 32'(ready), 32'h1);
    chk("t4_hit_248_data", instr, 32'h2A8);
    read(32'h048);
    chk("t4_miss_048", 32'(busy), 32'h1);
    wait_idle("t4_048_idle");
    read(32'h448);
    chk("t4_hit_448", 32'(ready), 32'h1);
    read(32'h248);
    chk("t4_rr_evict_248", 32'(busy), 32'h1);
    wait_idle("t4_248_idle");

    saw_ready = 1'b0;
    read(32'h1000);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_ready("t5_ready");
    chk("t5_crit", got_instr, 32'h10E0);
    wait_idle("t5_idle");
    read(32'h1000);
    chk("t5_remiss", 32'(busy), 32'h1);
    wait_idle("t5_idle2");
    read(32'h648);
    chk("t5_old_miss", 32'(busy), 32'h1);
    wait_idle("t5_idle3");

    read(32'h2000);
    for (int k = 0; k < 40 && !(mdr && mem_n == 2); k++) step();
    chk("t6_at_beat2", 32'(mem_n), 32'h2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_mreq", 32'(mreq), 32'h0);
    chk("t6_hits", hits, 32'h0);
    chk("t6_miss", misses, 32'h0);
    read(32'h2000);
    chk("t6_remiss", 32'(busy), 32'h1);
    chk("t6_miss1", misses, 32'h1);
    wait_idle("t6_idle");

    gap_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      if (!busy) begin
        ren   = ($urandom_range(0, 9) < 7);
        flush = ($urandom_range(0, 39) == 0);
        raddr = (32'($urandom_range(0, 5)) << 7) |
                (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2) |
                32'($urandom_range(0, 3));
      end else begin
        ren   = 1'($urandom_range(0, 1));
        flush = ($urandom_range(0, 30) == 0);
      end
      step();
    end
    ren = 1'b0;
    flush = 1'b0;
    wait_idle("rand_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
